// File: rtl/conv_pkg.sv
// Shared dimensions, FSM state type and word-to-byte address helper for the
// convolution layer controller.
package conv_pkg;

  localparam int IH = 4;  // iFM height
  localparam int IW = 4;  // iFM width
  localparam int K  = 3;  // square kernel size
  localparam int N  = 3;  // input channels
  localparam int M  = 3;  // output channels / kernels

  localparam int OH = IH - K + 1;
  localparam int OW = IW - K + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  // BRAM ports are byte addressed with 32-bit words.
  function automatic logic [31:0] byte_addr(input logic [31:0] word_idx);
    return word_idx << 2;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Six nested loop counters (m, oy, ox outer; c, ky, kx inner, kx fastest) and
// the iFM / kernel / oFM word-index arithmetic for the current position.
module conv_addr_gen #(
  parameter int IH = conv_pkg::IH,
  parameter int IW = conv_pkg::IW,
  parameter int K  = conv_pkg::K,
  parameter int N  = conv_pkg::N,
  parameter int M  = conv_pkg::M
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        step_inner,
  input  logic        step_outer,
  output logic        inner_first,
  output logic        inner_last,
  output logic        outer_last,
  output logic [31:0] ifm_idx,
  output logic [31:0] ker_idx,
  output logic [31:0] ofm_idx
);

  localparam int OH = IH - K + 1;
  localparam int OW = IW - K + 1;

  localparam logic [15:0] K_LAST  = 16'(K - 1);
  localparam logic [15:0] N_LAST  = 16'(N - 1);
  localparam logic [15:0] M_LAST  = 16'(M - 1);
  localparam logic [15:0] OH_LAST = 16'(OH - 1);
  localparam logic [15:0] OW_LAST = 16'(OW - 1);

  localparam logic [31:0] IW32   = 32'(IW);
  localparam logic [31:0] PLANE  = 32'(IH * IW);
  localparam logic [31:0] K32    = 32'(K);
  localparam logic [31:0] N32    = 32'(N);
  localparam logic [31:0] OW32   = 32'(OW);
  localparam logic [31:0] OPLANE = 32'(OH * OW);

  logic [15:0] m_q, oy_q, ox_q, c_q, ky_q, kx_q;
  logic        kx_wrap, ky_wrap, c_wrap, ox_wrap, oy_wrap, m_wrap;

  assign kx_wrap = (kx_q == K_LAST);
  assign ky_wrap = (ky_q == K_LAST);
  assign c_wrap  = (c_q  == N_LAST);
  assign ox_wrap = (ox_q == OW_LAST);
  assign oy_wrap = (oy_q == OH_LAST);
  assign m_wrap  = (m_q  == M_LAST);

  assign inner_first = (c_q == '0) && (ky_q == '0) && (kx_q == '0);
  assign inner_last  = c_wrap && ky_wrap && kx_wrap;
  assign outer_last  = m_wrap && oy_wrap && ox_wrap;

  // NOTE: state registers use non-blocking assignments so every counter
  // samples the pre-edge values of its neighbours, whatever the statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q  <= '0;
      oy_q <= '0;
      ox_q <= '0;
      c_q  <= '0;
      ky_q <= '0;
      kx_q <= '0;
    end else if (clear) begin
      m_q  <= '0;
      oy_q <= '0;
      ox_q <= '0;
      c_q  <= '0;
      ky_q <= '0;
      kx_q <= '0;
    end else begin
      if (step_inner) begin
        kx_q <= kx_wrap ? '0 : kx_q + 16'd1;
        if (kx_wrap) begin
          ky_q <= ky_wrap ? '0 : ky_q + 16'd1;
          if (ky_wrap) c_q <= c_wrap ? '0 : c_q + 16'd1;
        end
      end
      if (step_outer) begin
        ox_q <= ox_wrap ? '0 : ox_q + 16'd1;
        if (ox_wrap) begin
          oy_q <= oy_wrap ? '0 : oy_q + 16'd1;
          if (oy_wrap) m_q <= m_wrap ? '0 : m_q + 16'd1;
        end
      end
    end
  end

  assign ifm_idx = 32'(c_q) * PLANE
                 + (32'(oy_q) + 32'(ky_q)) * IW32
                 + 32'(ox_q) + 32'(kx_q);

  assign ker_idx = ((32'(m_q) * N32 + 32'(c_q)) * K32 + 32'(ky_q)) * K32
                 + 32'(kx_q);

  assign ofm_idx = 32'(m_q) * OPLANE + 32'(oy_q) * OW32 + 32'(ox_q);

endmodule

// File: rtl/conv_layer_ctrl.sv
// Convolution layer controller: sequences BRAM reads for an external MAC and
// writes one oFM word per output. Define CONV_CTRL_RELU_EN to clamp negative results to 0.
module conv_layer_ctrl #(
  parameter int IH = conv_pkg::IH,
  parameter int IW = conv_pkg::IW,
  parameter int K  = conv_pkg::K,
  parameter int N  = conv_pkg::N,
  parameter int M  = conv_pkg::M
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ps_control,
  output logic [31:0] pl_status,
  output logic [31:0] iFM_addr,
  output logic [3:0]  iFM_we,
  output logic [31:0] kernel_addr,
  output logic [3:0]  kernel_we,
  output logic [31:0] oFM_addr,
  output logic [31:0] oFM_wrdata,
  output logic [3:0]  oFM_we,
  output logic        mac_clear,
  output logic        mac_valid,
  input  logic [31:0] mac_result
);

  import conv_pkg::*;

  state_t      state_q, next_state;
  logic        run, ctrl_q, start;
  logic        drain_q;
  logic        mac_valid_q, mac_clear_q;
  logic [15:0] count_q;
  logic        load_issue, in_write;
  logic        inner_first, inner_last, outer_last;
  logic [31:0] ifm_idx, ker_idx, ofm_idx;
  logic [31:0] wr_value;
  logic [30:0] ctrl_unused;

  assign run         = ps_control[0];
  assign ctrl_unused = ps_control[31:1];

  // Only a rising edge of the start bit launches a run.
  assign start      = (state_q == IDLE) && run && !ctrl_q;
  assign load_issue = (state_q == LOAD) && run;
  assign in_write   = (state_q == WRITE);

  conv_addr_gen #(
    .IH(IH),
    .IW(IW),
    .K (K),
    .N (N),
    .M (M)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_q == IDLE),
    .step_inner (load_issue),
    .step_outer (in_write),
    .inner_first(inner_first),
    .inner_last (inner_last),
    .outer_last (outer_last),
    .ifm_idx    (ifm_idx),
    .ker_idx    (ker_idx),
    .ofm_idx    (ofm_idx)
  );

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    if (!run) next_state = IDLE;
               else if (inner_last) next_state = DRAIN;
      DRAIN:   if (!run) next_state = IDLE;
               else if (drain_q) next_state = WRITE;
      WRITE:   next_state = outer_last ? DONE : LOAD;
      DONE:    if (!run) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ctrl_q      <= 1'b0;
      drain_q     <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_clear_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= next_state;
      ctrl_q      <= run;
      drain_q     <= (state_q == DRAIN) && run && !drain_q;
      // Read data arrives one cycle after the address, so valid/clear trail it.
      mac_valid_q <= load_issue;
      mac_clear_q <= load_issue && inner_first;
      if (start)         count_q <= '0;
      else if (in_write) count_q <= count_q + 16'd1;
    end
  end

`ifdef CONV_CTRL_RELU_EN
  assign wr_value = mac_result[31] ? '0 : mac_result;
`else
  assign wr_value = mac_result;
`endif

  assign iFM_addr    = load_issue ? byte_addr(ifm_idx) : '0;
  assign kernel_addr = load_issue ? byte_addr(ker_idx) : '0;
  assign iFM_we      = 4'h0;
  assign kernel_we   = 4'h0;

  assign oFM_addr   = in_write ? byte_addr(ofm_idx) : '0;
  assign oFM_wrdata = in_write ? wr_value : '0;
  assign oFM_we     = in_write ? 4'hF : 4'h0;

  assign mac_valid = mac_valid_q;
  assign mac_clear = mac_clear_q;

  assign pl_status = {count_q, 14'b0,
                      (state_q == LOAD) || (state_q == DRAIN) || (state_q == WRITE),
                      (state_q == DONE)};

endmodule
